// File: rtl/mk_xsim_top_if.sv
// Beat channels between the portal core and the simulator message shims.
//   in_valid/in_beat/in_ready       : host-to-hardware beats, transfer = in_valid && in_ready
//   out_en_beat/out_beat/out_rdy    : hardware-to-host beats, transfer = out_en_beat && out_rdy
// master = message shim side, slave = portal core side.
interface mk_xsim_top_if;
  logic        in_valid;
  logic [31:0] in_beat;
  logic        in_ready;
  logic        out_en_beat;
  logic [31:0] out_beat;
  logic        out_rdy;

  modport master (
    output in_valid, in_beat, out_rdy,
    input  in_ready, out_en_beat, out_beat
  );

  modport slave (
    input  in_valid, in_beat, out_rdy,
    output in_ready, out_en_beat, out_beat
  );
endinterface

// File: rtl/mk_xsim_top.sv
// Portal core: decodes inbound beat messages into register-file writes,
// reads and echoes, and emits response messages on the outbound channel.
//   CLK, RST             : clock, synchronous active-high reset
//   bus (slave)          : inbound/outbound beat channels
//   in_portal/out_portal : constant PORTAL_ID
//   err_count            : number of discarded unknown-method messages (wraps)
//   busy                 : high whenever the decoder is not idle
module mk_xsim_top #(
  parameter int unsigned PORTAL_ID = 5,
  parameter int unsigned NUM_REGS  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  mk_xsim_top_if.slave bus,
  output logic [31:0] in_portal,
  output logic [31:0] out_portal,
  output logic [15:0] err_count,
  output logic        busy
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, ARGS, RESP} state_t;

  state_t      state;
  logic [15:0] method;
  logic [15:0] remaining;
  logic [1:0]  cnt;
  logic [31:0] arg0;
  logic [31:0] arg1;
  logic [31:0] rsp_b1;
  logic [31:0] rsp_b2;
  logic [1:0]  rsp_idx;
  logic [1:0]  rsp_last;
  logic [31:0] regs [NUM_REGS];

  logic          acc;
  logic          last_arg;
  logic [31:0]   arg0_nx;
  logic [31:0]   arg1_nx;
  logic          addr_ok;
  logic [AW-1:0] addr_idx;
  logic [31:0]   rd_data;
  logic [15:0]   hdr_method;
  logic [15:0]   hdr_len;
  logic          hdr_known;

  assign in_portal  = 32'(PORTAL_ID);
  assign out_portal = 32'(PORTAL_ID);

  // Argument values including the beat being accepted this cycle, so the
  // final beat can be acted on at the same edge that accepts it.
  always_comb begin
    acc        = bus.in_valid && bus.in_ready;
    arg0_nx    = arg0;
    arg1_nx    = arg1;
    if (acc && (state == ARGS)) begin
      if (cnt == 2'd0)      arg0_nx = bus.in_beat;
      else if (cnt == 2'd1) arg1_nx = bus.in_beat;
    end
    last_arg   = acc && (state == ARGS) && (remaining == 16'd1);
    addr_ok    = arg0_nx < 32'(NUM_REGS);
    addr_idx   = arg0_nx[AW-1:0];
    rd_data    = addr_ok ? regs[addr_idx] : 32'h0;
    hdr_method = bus.in_beat[31:16];
    hdr_len    = bus.in_beat[15:0];
    hdr_known  = hdr_method < 16'd3;
  end

  // Decoder FSM, register file and registered channel outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      method          <= '0;
      remaining       <= '0;
      cnt             <= '0;
      arg0            <= '0;
      arg1            <= '0;
      rsp_b1          <= '0;
      rsp_b2          <= '0;
      rsp_idx         <= '0;
      rsp_last        <= '0;
      regs            <= '{default: '0};
      err_count       <= '0;
      busy            <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.out_en_beat <= 1'b0;
      bus.out_beat    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (acc) begin
            method <= hdr_method;
            if (hdr_len <= 16'd1) begin
              // Header-only message: nothing to do beyond error accounting.
              if (!hdr_known) err_count <= err_count + 16'd1;
            end else begin
              state     <= ARGS;
              busy      <= 1'b1;
              remaining <= hdr_len - 16'd1;
              cnt       <= '0;
              arg0      <= '0;
              arg1      <= '0;
            end
          end
        end

        ARGS: begin
          if (acc) begin
            arg0      <= arg0_nx;
            arg1      <= arg1_nx;
            remaining <= remaining - 16'd1;
            if (cnt != 2'd2) cnt <= cnt + 2'd1;
            if (last_arg) begin
              case (method)
                16'd0: begin
                  if (addr_ok) regs[addr_idx] <= arg1_nx;
                  state <= IDLE;
                  busy  <= 1'b0;
                end
                16'd1: begin
                  state           <= RESP;
                  bus.in_ready    <= 1'b0;
                  bus.out_en_beat <= 1'b1;
                  bus.out_beat    <= {16'd0, 16'd3};
                  rsp_b1          <= arg0_nx;
                  rsp_b2          <= rd_data;
                  rsp_idx         <= '0;
                  rsp_last        <= 2'd2;
                end
                16'd2: begin
                  state           <= RESP;
                  bus.in_ready    <= 1'b0;
                  bus.out_en_beat <= 1'b1;
                  bus.out_beat    <= {16'd1, 16'd2};
                  rsp_b1          <= arg0_nx;
                  rsp_b2          <= '0;
                  rsp_idx         <= '0;
                  rsp_last        <= 2'd1;
                end
                default: begin
                  err_count <= err_count + 16'd1;
                  state     <= IDLE;
                  busy      <= 1'b0;
                end
              endcase
            end
          end
        end

        RESP: begin
          // out_beat only advances on an accepted transfer, so it holds under backpressure.
          if (bus.out_en_beat && bus.out_rdy) begin
            if (rsp_idx == rsp_last) begin
              state           <= IDLE;
              busy            <= 1'b0;
              bus.in_ready    <= 1'b1;
              bus.out_en_beat <= 1'b0;
              bus.out_beat    <= '0;
            end else begin
              rsp_idx      <= rsp_idx + 2'd1;
              bus.out_beat <= (rsp_idx == 2'd0) ? rsp_b1 : rsp_b2;
            end
          end
        end

        default: begin
          state           <= IDLE;
          busy            <= 1'b0;
          bus.in_ready    <= 1'b0;
          bus.out_en_beat <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mk_xsim_top.sv
// Self-checking bench for mk_xsim_top: directed scenarios plus randomized
// message traffic scored against a message-level reference model.
module tb_mk_xsim_top;

  logic        clk;
  logic        rst;
  logic [31:0] in_portal;
  logic [31:0] out_portal;
  logic [15:0] err_count;
  logic        busy;

  mk_xsim_top_if bus ();

  mk_xsim_top #(.PORTAL_ID(5), .NUM_REGS(16)) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .in_portal  (in_portal),
    .out_portal (out_portal),
    .err_count  (err_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_regs [16];
  logic [15:0] m_err;
  logic [31:0] exp_q [$];
  logic [31:0] msg [$];
  logic        mon_en;
  int          rdy_mode;
  logic        hold_pend;
  logic [31:0] hold_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: apply one whole message (in msg) to the register file.
  function automatic void model_apply();
    logic [15:0] meth, len;
    logic [31:0] a0, a1;
    meth = msg[0][31:16];
    len  = msg[0][15:0];
    if (len <= 16'd1) begin
      if (meth > 16'd2) m_err = m_err + 16'd1;
      return;
    end
    a0 = (len > 16'd1) ? msg[1] : 32'h0;
    a1 = (len > 16'd2) ? msg[2] : 32'h0;
    case (meth)
      16'd0: if (a0 < 32'd16) m_regs[a0[3:0]] = a1;
      16'd1: begin
        exp_q.push_back(32'h0000_0003);
        exp_q.push_back(a0);
        exp_q.push_back((a0 < 32'd16) ? m_regs[a0[3:0]] : 32'h0);
      end
      16'd2: begin
        exp_q.push_back(32'h0001_0002);
        exp_q.push_back(a0);
      end
      default: m_err = m_err + 16'd1;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send_beat(input logic [31:0] b);
    int t;
    bus.in_valid = 1'b1;
    bus.in_beat  = b;
    t = 0;
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("in_ready_timeout", 32'(t), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_msg(input bit use_model);
    if (use_model) model_apply();
    foreach (msg[i]) send_beat(msg[i]);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || bus.out_en_beat) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic read_msg(input logic [31:0] addr);
    msg = {32'h0001_0002, addr};
    send_msg(1'b1);
  endtask

  // Output monitor: drives out_rdy and scores every outbound transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      case (rdy_mode)
        0:       bus.out_rdy = 1'b1;
        1:       bus.out_rdy = 1'($urandom_range(0, 1));
        default: bus.out_rdy = 1'b0;
      endcase
      if (hold_pend) begin
        chk("hold_en", 32'(bus.out_en_beat), 32'd1);
        chk("hold_beat", bus.out_beat, hold_val);
      end
      hold_pend = 1'b0;
      if (bus.out_en_beat) begin
        if (bus.out_rdy) begin
          if (exp_q.size() == 0) chk("spurious_out", 32'(bus.out_en_beat), 32'd0);
          else chk("out_beat", bus.out_beat, exp_q.pop_front());
        end else begin
          hold_pend = 1'b1;
          hold_val  = bus.out_beat;
        end
      end
    end
  end

  initial begin
    logic [15:0] meth, nom, len;
    logic [31:0] addr, data;
    int r, k;

    foreach (m_regs[i]) m_regs[i] = '0;
    m_err        = '0;
    mon_en       = 1'b1;
    rdy_mode     = 0;
    hold_pend    = 1'b0;
    hold_val     = '0;
    bus.out_rdy  = 1'b1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_beat  = $urandom;

    // Reset held with traffic offered
    repeat (20) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_en", 32'(bus.out_en_beat), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("in_portal", in_portal, 32'd5);
    chk("out_portal", out_portal, 32'd5);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Write then read back, checking first-beat latency
    msg = {32'h0000_0003, 32'h0000_0004, 32'hCAFE_F00D};
    send_msg(1'b1);
    read_msg(32'h4);
    chk("rd_lat", 32'(bus.out_en_beat), 32'd1);
    chk("rd_first", bus.out_beat, 32'h0000_0003);
    wait_drain();

    // Echo under 3 cycles of backpressure
    rdy_mode = 2;
    msg = {32'h0002_0002, 32'h1234_5678};
    send_msg(1'b1);
    repeat (3) begin
      chk("echo_hold_en", 32'(bus.out_en_beat), 32'd1);
      chk("echo_hold_beat", bus.out_beat, 32'h0001_0002);
      chk("echo_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    rdy_mode = 0;
    wait_drain();

    // Unknown method with 3 trailing beats
    msg = {32'h0007_0004, $urandom, $urandom, $urandom};
    send_msg(1'b1);
    wait_drain();
    chk("err_unknown", 32'(err_count), 32'(m_err));
    read_msg(32'h0);
    wait_drain();

    // Out-of-range write and read
    msg = {32'h0000_0003, 32'd20, 32'hDEAD_BEEF};
    send_msg(1'b1);
    read_msg(32'd20);
    read_msg(32'd4);
    wait_drain();

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      r    = $urandom_range(0, 9);
      addr = 32'($urandom_range(0, 19));
      data = $urandom;
      if (r < 4)      begin meth = 16'd0; nom = 16'd3; end
      else if (r < 7) begin meth = 16'd1; nom = 16'd2; end
      else if (r < 9) begin meth = 16'd2; nom = 16'd2; end
      else            begin meth = 16'($urandom_range(3, 65535)); nom = 16'($urandom_range(0, 4)); end
      k   = $urandom_range(0, 5);
      len = nom;
      if (k == 0 && nom > 0) len = nom - 16'd1;
      else if (k == 1) len = nom + 16'($urandom_range(1, 2));
      msg = {{meth, len}};
      for (int i = 1; i < int'(len); i++) begin
        if (i == 1) msg.push_back((meth == 16'd2) ? data : addr);
        else if (i == 2) msg.push_back(data);
        else msg.push_back($urandom);
      end
      rdy_mode = $urandom_range(0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_msg(1'b1);
    end
    rdy_mode = 0;
    wait_drain();
    chk("err_random", 32'(err_count), 32'(m_err));
    for (int a = 0; a < 16; a++) read_msg(32'(a));
    wait_drain();

    // Reset during second beat of a read response
    msg = {32'h0000_0003, 32'h0000_0004, 32'h5A5A_1234};
    send_msg(1'b1);
    wait_drain();
    mon_en      = 1'b0;
    bus.out_rdy = 1'b0;
    msg = {32'h0001_0002, 32'h0000_0004};
    send_msg(1'b0);
    chk("rr_first", bus.out_beat, 32'h0000_0003);
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("rr_second_en", 32'(bus.out_en_beat), 32'd1);
    chk("rr_second", bus.out_beat, 32'h0000_0004);
    rst         = 1'b1;
    bus.out_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_busy", 32'(busy), 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("rr_out_en", 32'(bus.out_en_beat), 32'd0);
    end
    foreach (m_regs[i]) m_regs[i] = '0;
    m_err = '0;
    exp_q.delete();
    chk("rr_err", 32'(err_count), 32'd0);
    rdy_mode = 0;
    mon_en   = 1'b1;
    read_msg(32'h4);
    read_msg(32'h3);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
